// File: rtl/inv_pkg.sv
// Shared BN254 field parameters: operand width, operand type, base-field prime and the inverter state encoding.
package PARAMS_BN254_d0;

  localparam int unsigned WIDTH = 268;

  typedef logic [WIDTH-1:0] M_tilde12_t;

  localparam M_tilde12_t Mod =
    268'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOOP,
    FIX,
    DONE
  } inv_state_e;

endpackage

// File: rtl/inv_halve_mod.sv
// Halving modulo odd N: y = x/2 when x is even, (x+N)/2 otherwise; x+N is formed one bit wider.
module inv_halve_mod #(
  parameter int unsigned WIDTH = 268
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] y_c
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = x[0] ? ({1'b0, x} + {1'b0, n}) : {1'b0, x};
    y_c = WIDTH'(sum >> 1);
  end

endmodule

// File: rtl/inv.sv
// Modular inverter R = A^-1 mod N by binary extended Euclid, one step per clock.
// Define INV_CONST_TIME_EN to run LOOP for exactly MAX_ITER cycles (data-independent latency).
module inv
  import PARAMS_BN254_d0::*;
#(
  parameter int unsigned WIDTH    = PARAMS_BN254_d0::WIDTH,
  parameter int unsigned MAX_ITER = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             I_START,
  input  logic [WIDTH-1:0] I_DATA_N,
  input  logic [WIDTH-1:0] I_WDATA,
  output logic             O_BUSY,
  output logic             O_VALID,
  output logic [WIDTH-1:0] O_RDATA,
  output logic             O_ERR
);

  localparam int unsigned CW = $clog2(MAX_ITER + 1);

  inv_state_e state, state_n;

  logic [WIDTH-1:0] a_sh, a_n, n_q, n_n;
  logic [WIDTH-1:0] u, u_n, v, v_n, x1, x1_n, x2, x2_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             busy_q, busy_n, valid_q, valid_n, err_q, err_n;
  logic [WIDTH-1:0] rdata_q, rdata_n;

  logic [WIDTH-1:0] h1_c, h2_c;
  logic [WIDTH-1:0] su_c, sv_c, sx1_c, sx2_c;
  logic [WIDTH:0]   rem, d12, d21;
  logic [WIDTH-1:0] sel, fix;
  logic             done_c, ok;

  inv_halve_mod #(.WIDTH(WIDTH)) u_h1 (.x(x1), .n(n_q), .y_c(h1_c));
  inv_halve_mod #(.WIDTH(WIDTH)) u_h2 (.x(x2), .n(n_q), .y_c(h2_c));

  // One Euclid step plus the mod-N coefficient subtractions (add N back on borrow).
  always_comb begin
    rem = {u, a_sh[WIDTH-1]};
    d12 = {1'b0, x1} - {1'b0, x2};
    d21 = {1'b0, x2} - {1'b0, x1};
    su_c  = u;
    sv_c  = v;
    sx1_c = x1;
    sx2_c = x2;
    if (!u[0]) begin
      su_c  = u >> 1;
      sx1_c = h1_c;
    end else if (!v[0]) begin
      sv_c  = v >> 1;
      sx2_c = h2_c;
    end else if (u >= v) begin
      su_c  = u - v;
      sx1_c = d12[WIDTH] ? WIDTH'(d12 + {1'b0, n_q}) : WIDTH'(d12);
    end else begin
      sv_c  = v - u;
      sx2_c = d21[WIDTH] ? WIDTH'(d21 + {1'b0, n_q}) : WIDTH'(d21);
    end
    done_c = (u == WIDTH'(1)) || (v == WIDTH'(1)) || (u == '0);
  end

  // Result selection and final range fix.
  always_comb begin
    ok  = 1'b1;
    sel = '0;
    if (u == WIDTH'(1)) begin
      sel = x1;
    end else if (v == WIDTH'(1)) begin
      sel = x2;
    end else begin
      ok = 1'b0;
    end
    fix = (sel >= n_q) ? (sel - n_q) : sel;
  end

  always_comb begin
    state_n = state;
    a_n     = a_sh;
    n_n     = n_q;
    u_n     = u;
    v_n     = v;
    x1_n    = x1;
    x2_n    = x2;
    cnt_n   = cnt;
    busy_n  = busy_q;
    valid_n = 1'b0;
    rdata_n = rdata_q;
    err_n   = err_q;
    case (state)
      IDLE: begin
        if (I_START) begin
          a_n     = I_WDATA;
          n_n     = I_DATA_N;
          u_n     = '0;
          v_n     = I_DATA_N;
          x1_n    = WIDTH'(1);
          x2_n    = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          err_n   = 1'b0;
          state_n = INIT;
        end
      end
      INIT: begin
        // Restoring reduction, one operand bit per cycle, MSB first.
        u_n   = (rem >= {1'b0, n_q}) ? WIDTH'(rem - {1'b0, n_q}) : WIDTH'(rem);
        a_n   = a_sh << 1;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          cnt_n   = '0;
          state_n = LOOP;
        end
      end
      LOOP: begin
`ifdef INV_CONST_TIME_EN
        if (!done_c) begin
          u_n  = su_c;
          v_n  = sv_c;
          x1_n = sx1_c;
          x2_n = sx2_c;
        end
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(MAX_ITER - 1)) begin
          state_n = FIX;
        end
`else
        if (done_c) begin
          state_n = FIX;
        end else begin
          u_n   = su_c;
          v_n   = sv_c;
          x1_n  = sx1_c;
          x2_n  = sx2_c;
          cnt_n = cnt + CW'(1);
          if (cnt == CW'(MAX_ITER - 1)) begin
            state_n = FIX;
          end
        end
`endif
      end
      FIX: begin
        rdata_n = ok ? fix : '0;
        err_n   = !ok;
        valid_n = 1'b1;
        busy_n  = 1'b0;
        state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      a_sh    <= '0;
      n_q     <= '0;
      u       <= '0;
      v       <= '0;
      x1      <= '0;
      x2      <= '0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      a_sh    <= a_n;
      n_q     <= n_n;
      u       <= u_n;
      v       <= v_n;
      x1      <= x1_n;
      x2      <= x2_n;
      cnt     <= cnt_n;
      busy_q  <= busy_n;
      valid_q <= valid_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
    end
  end

  assign O_BUSY  = busy_q;
  assign O_VALID = valid_q;
  assign O_RDATA = rdata_q;
  assign O_ERR   = err_q;

endmodule

// File: tb/tb_inv.sv
// Bench for inv: Fermat-inverse reference plus a binary-gcd step count for watchdog and latency.
module tb_inv;
  import PARAMS_BN254_d0::*;

  localparam int W  = 268;
  localparam int MI = 2 * W;

  logic         clk;
  logic         rstn;
  logic         I_START;
  logic [W-1:0] I_DATA_N;
  logic [W-1:0] I_WDATA;
  logic         O_BUSY;
  logic         O_VALID;
  logic [W-1:0] O_RDATA;
  logic         O_ERR;

  inv dut (
    .clk      (clk),
    .rstn     (rstn),
    .I_START  (I_START),
    .I_DATA_N (I_DATA_N),
    .I_WDATA  (I_WDATA),
    .O_BUSY   (O_BUSY),
    .O_VALID  (O_VALID),
    .O_RDATA  (O_RDATA),
    .O_ERR    (O_ERR)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int start_cyc = 0;
  int nvalid = 0;
  int last_lat = 0;
  logic         exp_pend = 1'b0;
  logic [W-1:0] exp_r = '0;
  logic         exp_e = 1'b0;
  int           exp_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] n);
    logic [2*W-1:0] r, x, nn;
    nn = {{W{1'b0}}, n};
    r  = 1;
    x  = {{W{1'b0}}, b};
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % nn;
      x = (x * x) % nn;
    end
    return W'(r);
  endfunction

  // Result from Fermat; binary gcd on (A mod N, N) only decides error/watchdog and loop length.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] n,
                                output logic [W-1:0] r, output logic e, output int lat);
    logic [W-1:0] u, v;
    int s;
    bit ok;
    int loopc;
    u = a % n;
    v = n;
    s = 0;
    while (s < MI && !(u == 1 || v == 1 || u == 0)) begin
      if (!u[0]) u = u >> 1;
      else if (!v[0]) v = v >> 1;
      else if (u >= v) u = u - v;
      else v = v - u;
      s++;
    end
    ok = (u == 1) || (v == 1);
    e  = !ok;
    r  = ok ? modexp(a % n, n - W'(2), n) : '0;
    loopc = (s < MI) ? s + 1 : MI;
`ifdef INV_CONST_TIME_EN
    lat = W + MI + 2;
`else
    lat = W + loopc + 2;
`endif
  endfunction

  // Compare process: every O_VALID pulse is checked against the pending model expectation.
  always @(negedge clk) begin
    if (O_VALID) begin
      nvalid <= nvalid + 1;
      chk("valid_expected", W'(O_VALID), W'(exp_pend));
      if (exp_pend) begin
        last_lat = cyc - start_cyc + 1;
        chk("rdata", O_RDATA, exp_r);
        chk("err", W'(O_ERR), W'(exp_e));
        chk("latency", W'(last_lat), W'(exp_lat));
        chk("busy_at_valid", W'(O_BUSY), W'(0));
      end
    end
  end

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] n, input int hold);
    int v0;
    int guard;
    model(a, n, exp_r, exp_e, exp_lat);
    v0 = nvalid;
    exp_pend = 1'b1;
    @(negedge clk);
    I_WDATA  = a;
    I_DATA_N = n;
    I_START  = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk);
    chk("busy_after_start", W'(O_BUSY), W'(1));
    chk("err_cleared", W'(O_ERR), W'(0));
    repeat (hold - 1) @(negedge clk);
    I_START = 1'b0;
    guard = 0;
    while (nvalid == v0 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    if (nvalid == v0) chk("valid_timeout", W'(0), W'(1));
    repeat (3) @(negedge clk);
    chk("busy_after_done", W'(O_BUSY), W'(0));
    chk("one_valid", W'(nvalid - v0), W'(1));
    exp_pend = 1'b0;
  endtask

  localparam logic [W-1:0] BIGA =
    268'h99ac9110cbcdf1924248781ca049785e49e45f9c9b24c70f9fc7db57b20c5d8ad2a;

  initial begin
    logic [W-1:0]   mr, first_r, ones;
    logic           me;
    int             ml, lat1;
    logic [2*W-1:0] prod;
    int             v0;

    rstn     = 1'b1;
    I_START  = 1'b0;
    I_DATA_N = Mod;
    I_WDATA  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(O_BUSY), W'(0));
    chk("rst_valid", W'(O_VALID), W'(0));
    chk("rst_rdata", O_RDATA, W'(0));
    chk("rst_err", W'(O_ERR), W'(0));
    rstn = 1'b0;

    // Hand-computed pins for the reference model.
    model(W'(3), W'(7), mr, me, ml);
    chk("model_3_mod7", mr, W'(5));
`ifdef INV_CONST_TIME_EN
    chk("model_lat_3_mod7", W'(ml), W'(806));
`else
    chk("model_lat_3_mod7", W'(ml), W'(274));
`endif
    model(W'(1), Mod, mr, me, ml);
    chk("model_one", mr, W'(1));
`ifdef INV_CONST_TIME_EN
    chk("model_lat_one", W'(ml), W'(806));
`else
    chk("model_lat_one", W'(ml), W'(271));
`endif
    model(Mod - W'(1), Mod, mr, me, ml);
    chk("model_minus_one", mr, Mod - W'(1));
    model(W'(0), Mod, mr, me, ml);
    chk("model_zero_err", W'(me), W'(1));

    // Main vector, repeated with unchanged input.
    run(BIGA, Mod, 1);
    first_r = O_RDATA;
    lat1 = last_lat;
    if (!exp_e) begin
      prod = ({{W{1'b0}}, BIGA % Mod} * {{W{1'b0}}, O_RDATA}) % {{W{1'b0}}, Mod};
      chk("inverse_product", W'(prod), W'(1));
    end
    run(BIGA, Mod, 1);
    chk("repeat_identical", O_RDATA, first_r);

    run(W'(1), Mod, 1);
`ifdef INV_CONST_TIME_EN
    chk("const_latency_equal", W'(last_lat), W'(lat1));
`endif
    run(Mod - W'(1), Mod, 1);
    run(W'(0), Mod, 1);
    run(Mod, Mod, 1);
    run(W'(3), W'(7), 1);
    ones = '1;
    run(ones, Mod, 1);

    // Start held for 3 cycles: exactly one completion.
    run(W'(5), Mod, 3);

    // Reset in the middle of LOOP: busy drops, no completion appears.
    @(negedge clk);
    I_WDATA  = BIGA;
    I_DATA_N = Mod;
    I_START  = 1'b1;
    @(negedge clk);
    I_START = 1'b0;
    repeat (W + 30) @(negedge clk);
    v0 = nvalid;
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_busy", W'(O_BUSY), W'(0));
    chk("midrst_valid", W'(O_VALID), W'(0));
    rstn = 1'b0;
    repeat (W + MI + 20) @(negedge clk);
    chk("midrst_no_valid", W'(nvalid - v0), W'(0));
    run(W'(1), Mod, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
